// File: rtl/clock_select_pkg.sv
// Purpose : shared types and selector-code decode for the processor clock selector.
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package clock_select_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        WAIT_NEW = 2'd2
    } state_t;

    // All-ones selector code; the top truncates it to its selector width.
    // It is always out of range, so it decodes as stop.
    localparam logic [31:0] STOP_CODE = '1;

    function automatic logic is_channel(input int unsigned code, input int unsigned n_ch);
        return code < n_ch;
    endfunction

    function automatic logic is_full(input int unsigned code, input int unsigned n_ch);
        return code == n_ch;
    endfunction

    function automatic logic is_step(input int unsigned code, input int unsigned n_ch);
        return code == n_ch + 1;
    endfunction

    function automatic logic is_stop(input int unsigned code, input int unsigned n_ch);
        return code > n_ch + 1;
    endfunction

endpackage

// File: rtl/clock_select_gen_sync.sv
// Purpose : multi-flop synchroniser for one asynchronous bit, with rising-edge detect.
// Latency : level follows d after STAGES clock edges; rise is combinational on the synced level.
// Backpressure: none.
// Ports: clock/reset (async, active-high), d (async input), level (synced), rise (one-cycle pulse).
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign level = r_sync[STAGES-1];
    assign rise  = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/clock_select_gen.sv
// Purpose : glitch-free selection of a processor clock (slow channel, full speed, single step or stop).
// Latency : channel edge reaches clock_out SYNC_STAGES+1 cycles later; switches take drain + wait-new time.
// Backpressure: none; sel changes are absorbed by the switch protocol (busy high while it runs).
// Ports: clock, reset (async, active-high); clk_in[N_CH], sel, step (async key) in;
//        clock_out, tick, busy, active_sel out, all registered in the clock domain.
module clock_select_gen
    import clock_select_pkg::*;
#(
    parameter int N_CH           = 8,
    parameter int SEL_W          = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STEP_HIGH      = 4,
    parameter int SWITCH_TIMEOUT = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_CH-1:0]  clk_in,
    input  logic [SEL_W-1:0] sel,
    input  logic             step,
    output logic             clock_out,
    output logic             tick,
    output logic             busy,
    output logic [SEL_W-1:0] active_sel
);

    localparam int              CNT_W  = $clog2(SWITCH_TIMEOUT + 1);
    localparam int              STEP_W = $clog2(STEP_HIGH + 1);
    localparam int              PAD_W  = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] L_STOP = STOP_CODE[SEL_W-1:0];

    // Synchronised inputs. Channel selection works on levels only, so the
    // per-channel rise pulses are left unused.
    logic [N_CH-1:0]  w_clk_lvl;
    logic [N_CH-1:0]  w_unused_clk_rise;
    logic             w_step_lvl;
    logic             w_step_rise;
    logic [PAD_W-1:0] w_lvl_pad;

    for (genvar g = 0; g < N_CH; g++) begin : g_sync
        sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
            .clock (clock),
            .reset (reset),
            .d     (clk_in[g]),
            .level (w_clk_lvl[g]),
            .rise  (w_unused_clk_rise[g])
        );
    end

    sync_edge #(.STAGES(SYNC_STAGES)) u_step_sync (
        .clock (clock),
        .reset (reset),
        .d     (step),
        .level (w_step_lvl),
        .rise  (w_step_rise)
    );

    // Zero-extended to the full code space so any selector code indexes safely.
    assign w_lvl_pad = PAD_W'(w_clk_lvl);

    state_t             r_state, w_state_n;
    logic [SEL_W-1:0]   r_active, w_active_n;
    logic [SEL_W-1:0]   r_pending, w_pending_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic [STEP_W-1:0]  r_step_cnt, w_step_cnt_n, w_step_cnt_follow;
    logic               r_clock_out, w_clock_out_n;
    logic               r_tick, r_busy;
    logic               w_follow, w_new_low, w_timeout;

    // Next clock_out level if we keep following the active source.
    always_comb begin
        w_follow          = 1'b0;
        w_step_cnt_follow = r_step_cnt;
        if (is_channel(32'(r_active), N_CH)) begin
            w_follow = w_lvl_pad[r_active];
        end else if (is_full(32'(r_active), N_CH)) begin
            w_follow = ~r_clock_out;
        end else if (is_step(32'(r_active), N_CH)) begin
            // r_step_cnt holds the high cycles still owed after the current one;
            // step edges arriving while high are simply not looked at.
            if (r_clock_out) begin
                if (r_step_cnt != '0) begin
                    w_follow          = 1'b1;
                    w_step_cnt_follow = r_step_cnt - STEP_W'(1);
                end
            end else if (w_step_lvl && w_step_rise) begin
                w_follow          = 1'b1;
                w_step_cnt_follow = STEP_W'(STEP_HIGH - 1);
            end
        end
    end

    // Step, full-speed and stop targets have no level of their own to wait for.
    assign w_new_low = is_channel(32'(r_pending), N_CH) ? ~w_lvl_pad[r_pending] : 1'b1;
    assign w_timeout = (r_cnt == CNT_W'(SWITCH_TIMEOUT - 1));

    always_comb begin
        w_state_n     = r_state;
        w_active_n    = r_active;
        w_pending_n   = r_pending;
        w_cnt_n       = r_cnt + CNT_W'(1);
        w_step_cnt_n  = r_step_cnt;
        w_clock_out_n = 1'b0;
        unique case (r_state)
            RUN: begin
                w_cnt_n       = '0;
                w_clock_out_n = w_follow;
                w_step_cnt_n  = w_step_cnt_follow;
                if (sel != r_active) begin
                    w_pending_n = sel;
                    w_state_n   = DRAIN;
                end
            end
            DRAIN: begin
                w_pending_n = sel;
                if (r_clock_out && !w_timeout) begin
                    // Let the current high phase finish on the old source.
                    w_clock_out_n = w_follow;
                    w_step_cnt_n  = w_step_cnt_follow;
                end else begin
                    w_state_n = WAIT_NEW;
                    w_cnt_n   = '0;
                end
            end
            WAIT_NEW: begin
                if (w_new_low || w_timeout) begin
                    w_active_n = r_pending;
                    w_state_n  = RUN;
                    w_cnt_n    = '0;
                end
            end
            default: begin
                w_state_n = RUN;
                w_cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_active    <= L_STOP;
            r_pending   <= L_STOP;
            r_cnt       <= '0;
            r_step_cnt  <= '0;
            r_clock_out <= 1'b0;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_active    <= w_active_n;
            r_pending   <= w_pending_n;
            r_cnt       <= w_cnt_n;
            r_step_cnt  <= w_step_cnt_n;
            r_clock_out <= w_clock_out_n;
            r_tick      <= w_clock_out_n & ~r_clock_out;
            r_busy      <= (w_state_n != RUN);
        end
    end

    assign clock_out  = r_clock_out;
    assign tick       = r_tick;
    assign busy       = r_busy;
    assign active_sel = r_active;

endmodule
